tdc_multi_ch_packer: RTL and testbench

- Multi-channel successor to the single-channel TDC timestamp path.
- Takes per-channel fine-code hit strobes from the delay-line encoders and stamps each hit with a shared internal coarse counter.
- Buffers hits per channel and merges all channels round-robin into one 64-bit valid/ready stream that feeds the external readout FIFO.
- Adds per-channel enable, per-channel overflow and drop counting, and a drained indicator.

---
 rtl/tdc_pkg.sv | 35 +++
 rtl/tdc_ch_buffer.sv | 65 ++++++
 rtl/tdc_multi_ch_packer.sv | 140 ++++++++++++++
 tb/tb_tdc_multi_ch_packer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the multi-channel TDC packer.
// Defines the output word layout: channel id at the top, truncated coarse time, then the fine code.
package tdc_pkg;

   localparam int unsigned TDC_WORD_WIDTH = 64;

   function automatic int unsigned ch_id_w(input int unsigned num_ch);
      return (num_ch < 2) ? 1 : $clog2(num_ch);
   endfunction

   function automatic int unsigned coarse_field_w(input int unsigned num_ch,
                                                  input int unsigned fine_w);
      return TDC_WORD_WIDTH - ch_id_w(num_ch) - fine_w;
   endfunction

   // Layout: {ch_id, coarse[low bits], fine}; coarse bits above the field are dropped.
   function automatic logic [TDC_WORD_WIDTH-1:0] pack_word(
      input int unsigned               num_ch,
      input int unsigned               fine_w,
      input logic [TDC_WORD_WIDTH-1:0] ch,
      input logic [TDC_WORD_WIDTH-1:0] coarse,
      input logic [TDC_WORD_WIDTH-1:0] fine
   );
      int unsigned                cw;
      logic [TDC_WORD_WIDTH-1:0]  cmask;
      logic [TDC_WORD_WIDTH-1:0]  fmask;
      cw    = coarse_field_w(num_ch, fine_w);
      cmask = (TDC_WORD_WIDTH'(1) << cw) - TDC_WORD_WIDTH'(1);
      fmask = (TDC_WORD_WIDTH'(1) << fine_w) - TDC_WORD_WIDTH'(1);
      return (ch << (TDC_WORD_WIDTH - ch_id_w(num_ch)))
           | ((coarse & cmask) << fine_w)
           | (fine & fmask);
   endfunction

endpackage

// File: rtl/tdc_ch_buffer.sv
// Per-channel hit FIFO with registered head data and registered full/empty flags.
// A push into a full buffer is accepted when the same cycle pops.
module tdc_ch_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             push_ok;

   always_comb begin
      push_ok    = push & (~full | pop);
      rd_ptr_nxt = rd_ptr + AW'(pop);
      count_nxt  = count + CW'(push_ok) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= wr_data;
   end

   // Head register tracks the entry at the post-update read pointer (write-through when it is the new word).
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         rd_data <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr  <= rd_ptr_nxt;
         count   <= count_nxt;
         full    <= (count_nxt == CW'(DEPTH));
         empty   <= (count_nxt == '0);
         rd_data <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/tdc_multi_ch_packer.sv
// Multi-channel TDC timestamp packer: stamps per-channel hits with a shared coarse counter,
// buffers them per channel and merges them round-robin into one 64-bit valid/ready stream.
module tdc_multi_ch_packer
   import tdc_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned COARSE_WIDTH   = 56,
   parameter int unsigned FINE_WIDTH     = 8,
   parameter int unsigned CH_BUF_DEPTH   = 4,
   parameter int unsigned DROP_CNT_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             clr_n,
   input  logic                             run,
   input  logic                             clr,
   input  logic [NUM_CH-1:0]                ch_en,
   input  logic [NUM_CH-1:0]                hit_vld,
   input  logic [NUM_CH*FINE_WIDTH-1:0]     hit_fine,
   output logic [TDC_WORD_WIDTH-1:0]        m_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             rdy,
   output logic                             overflow,
   output logic [NUM_CH-1:0]                ch_overflow,
   output logic [NUM_CH*DROP_CNT_WIDTH-1:0] drop_cnt
);

   localparam int unsigned CH_ID_W = ch_id_w(NUM_CH);
   localparam int unsigned ENTRY_W = COARSE_WIDTH + FINE_WIDTH;

   if (CH_ID_W + FINE_WIDTH >= TDC_WORD_WIDTH) begin : g_bad_cfg
      $error("tdc_multi_ch_packer: channel id plus fine code leave no room for coarse time");
   end

   logic [COARSE_WIDTH-1:0] coarse;
   logic [NUM_CH-1:0]       cap;
   logic [NUM_CH-1:0]       pop;
   logic [NUM_CH-1:0]       full;
   logic [NUM_CH-1:0]       empty;
   logic [ENTRY_W-1:0]      rd_data [NUM_CH];
   logic [CH_ID_W-1:0]      ptr;
   logic [CH_ID_W-1:0]      gnt;
   logic [CH_ID_W-1:0]      idx;
   logic                    gnt_vld;
   logic                    load;
   logic [ENTRY_W-1:0]      sel_entry;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)     coarse <= '0;
      else if (clr)   coarse <= '0;
      else if (run)   coarse <= coarse + COARSE_WIDTH'(1);
   end

   assign load = ~m_valid | m_ready;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt       = ptr;
      idx       = '0;
      sel_entry = '0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = CH_ID_W'((32'(ptr) + k) % NUM_CH);
         if (!gnt_vld && !empty[idx]) begin
            gnt_vld   = 1'b1;
            gnt       = idx;
            sel_entry = rd_data[idx];
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic                      drop;
      logic                      ovf_q;
      logic [DROP_CNT_WIDTH-1:0] cnt_q;

      assign cap[i] = hit_vld[i] & ch_en[i] & run & ~clr;
      assign pop[i] = load & gnt_vld & (gnt == CH_ID_W'(i)) & ~clr;
      assign drop   = cap[i] & full[i] & ~pop[i];

      tdc_ch_buffer #(
         .DEPTH (CH_BUF_DEPTH),
         .WIDTH (ENTRY_W)
      ) u_buf (
         .clk     (clk),
         .clr_n   (clr_n),
         .flush   (clr),
         .push    (cap[i]),
         .wr_data ({coarse, hit_fine[i*FINE_WIDTH +: FINE_WIDTH]}),
         .pop     (pop[i]),
         .rd_data (rd_data[i]),
         .full    (full[i]),
         .empty   (empty[i])
      );

      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
         end else if (clr) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
         end else if (drop) begin
            ovf_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + DROP_CNT_WIDTH'(1);
         end
      end

      assign ch_overflow[i]                                   = ovf_q;
      assign drop_cnt[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH]     = cnt_q;
   end

   // Output word register; holds while stalled, refills from the granted buffer.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         ptr     <= CH_ID_W'(NUM_CH - 1);
      end else if (clr) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         ptr     <= CH_ID_W'(NUM_CH - 1);
      end else if (load) begin
         if (gnt_vld) begin
            m_valid <= 1'b1;
            m_data  <= pack_word(NUM_CH, FINE_WIDTH,
                                 TDC_WORD_WIDTH'(gnt),
                                 TDC_WORD_WIDTH'(sel_entry[ENTRY_W-1:FINE_WIDTH]),
                                 TDC_WORD_WIDTH'(sel_entry[FINE_WIDTH-1:0]));
            ptr     <= gnt;
         end else begin
            m_valid <= 1'b0;
         end
      end
   end

   assign rdy      = (&empty) & ~m_valid;
   assign overflow = |ch_overflow;

endmodule

// File: tb/tb_tdc_multi_ch_packer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_tdc_multi_ch_packer;

   localparam int NCH   = 4;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         clr_n = 1'b0;
   logic         run = 1'b0;
   logic         clr = 1'b0;
   logic [3:0]   ch_en = 4'hF;
   logic [3:0]   hit_vld = 4'h0;
   logic [31:0]  hit_fine = '0;
   logic [63:0]  m_data;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic         rdy;
   logic         overflow;
   logic [3:0]   ch_overflow;
   logic [63:0]  drop_cnt;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   tdc_multi_ch_packer #(
      .NUM_CH(4), .COARSE_WIDTH(56), .FINE_WIDTH(8), .CH_BUF_DEPTH(4), .DROP_CNT_WIDTH(16)
   ) dut (
      .clk(clk), .clr_n(clr_n), .run(run), .clr(clr), .ch_en(ch_en),
      .hit_vld(hit_vld), .hit_fine(hit_fine), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .rdy(rdy), .overflow(overflow), .ch_overflow(ch_overflow),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: per-channel queues of finished words, one output slot.
   logic [63:0] mq [NCH][$];
   logic        mv;
   logic [63:0] md;
   int          mptr;
   logic [55:0] mcoarse;
   logic [3:0]  movf;
   logic [15:0] mdc [NCH];
   int          m_pc;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         mq[i].delete();
         mdc[i] = '0;
      end
      mv = 1'b0; md = '0; mptr = NCH - 1; mcoarse = '0; movf = '0;
   endtask

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n || clr) begin
         model_reset();
      end else begin
         if (!mv || m_ready) begin
            m_pc = -1;
            for (int k = 1; k <= NCH; k++)
               if (m_pc < 0 && mq[(mptr + k) % NCH].size() > 0) m_pc = (mptr + k) % NCH;
            if (m_pc >= 0) begin
               mv = 1'b1; md = mq[m_pc].pop_front(); mptr = m_pc;
            end else begin
               mv = 1'b0;
            end
         end
         if (run) begin
            for (int i = 0; i < NCH; i++) begin
               if (hit_vld[i] && ch_en[i]) begin
                  if (mq[i].size() < DEPTH) begin
                     mq[i].push_back({2'(i), mcoarse[53:0], hit_fine[i*8 +: 8]});
                  end else begin
                     movf[i] = 1'b1;
                     if (mdc[i] != 16'hFFFF) mdc[i] = mdc[i] + 16'd1;
                  end
               end
            end
            mcoarse = mcoarse + 56'd1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] model_drop_flat();
      logic [63:0] f;
      for (int i = 0; i < NCH; i++) f[i*16 +: 16] = mdc[i];
      return f;
   endfunction

   function automatic bit model_rdy();
      bit r;
      r = !mv;
      for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_valid", 64'(m_valid), 64'(mv));
         if (mv) check("m_data", m_data, md);
         check("rdy", 64'(rdy), 64'(model_rdy()));
         check("ch_overflow", 64'(ch_overflow), 64'(movf));
         check("overflow", 64'(overflow), 64'(|movf));
         check("drop_cnt", drop_cnt, model_drop_flat());
      end
   end

   task automatic clr_pulse();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_rdy", 64'(rdy), 64'd1);
      check("rst_data", m_data, 64'd0);
      check("rst_ovf", 64'(ch_overflow), 64'd0);
      check("rst_drop", drop_cnt, 64'd0);

      // Single hit on ch0 at coarse=100.
      clr_n = 1'b1;
      run   = 1'b1;
      repeat (100) @(negedge clk);
      hit_vld = 4'b0001; hit_fine[7:0] = 8'h2A;
      @(negedge clk);
      hit_vld = 4'b0000;
      check("lat_early", 64'(m_valid), 64'd0);
      @(negedge clk);
      check("lat_valid", 64'(m_valid), 64'd1);
      check("lat_word", m_data, 64'h0000_0000_0000_642A);

      // Two four-channel bursts, round-robin starting at channel 0 each time.
      clr_pulse();
      check("clr_valid", 64'(m_valid), 64'd0);
      for (int b = 0; b < 2; b++) begin
         hit_vld = 4'hF;
         for (int i = 0; i < NCH; i++) hit_fine[i*8 +: 8] = 8'(8'h10 + 16 * b + i);
         @(negedge clk);
         hit_vld = 4'h0;
         for (int i = 0; i < NCH; i++) begin
            @(negedge clk);
            check("burst_id", 64'(m_data[63:62]), 64'(i));
            check("burst_fine", 64'(m_data[7:0]), 64'(8'h10 + 16 * b + i));
         end
      end
      @(negedge clk);
      check("burst_done", 64'(m_valid), 64'd0);

      // Stall: five ch2 hits fit (4 buffered + output register), the sixth drops.
      clr_pulse();
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         hit_vld = 4'b0100; hit_fine[23:16] = 8'(8'h30 + k);
         @(negedge clk);
      end
      hit_vld = 4'b0000;
      check("fill_no_ovf", 64'(ch_overflow), 64'd0);
      check("fill_head", 64'(m_data[7:0]), 64'h30);
      hit_vld = 4'b0100; hit_fine[23:16] = 8'h35;
      @(negedge clk);
      hit_vld = 4'b0000;
      check("drop_flag", 64'(ch_overflow), 64'b0100);
      check("drop_any", 64'(overflow), 64'd1);
      check("drop_cnt2", 64'(drop_cnt[47:32]), 64'd1);

      // Full buffer popped in the same cycle as a new hit: accepted.
      m_ready = 1'b1; hit_vld = 4'b0100; hit_fine[23:16] = 8'h36;
      @(negedge clk);
      m_ready = 1'b0; hit_vld = 4'b0000;
      check("pop_push_cnt", 64'(drop_cnt[47:32]), 64'd1);
      check("pop_push_head", 64'(m_data[7:0]), 64'h31);
      @(negedge clk);
      m_ready = 1'b1;
      for (int k = 0; k < 40 && !rdy; k++) @(negedge clk);
      check("drain_rdy", 64'(rdy), 64'd1);

      // run=0 and ch_en=0 hits ignored; coarse holds at 0 while run=0.
      run = 1'b0;
      clr_pulse();
      hit_vld = 4'hF;
      @(negedge clk);
      hit_vld = 4'h0;
      repeat (4) @(negedge clk);
      check("run0_valid", 64'(m_valid), 64'd0);
      check("run0_rdy", 64'(rdy), 64'd1);
      ch_en = 4'b1101; run = 1'b1;
      hit_vld = 4'b1010; hit_fine[15:8] = 8'h55; hit_fine[31:24] = 8'h77;
      @(negedge clk);
      hit_vld = 4'h0; ch_en = 4'hF;
      @(negedge clk);
      check("hold_word", m_data, 64'hC000_0000_0000_0077);
      @(negedge clk);
      check("en_ignored", 64'(m_valid), 64'd0);
      check("en_no_drop", drop_cnt, 64'd0);

      // Partially full with drops, then synchronous clear.
      m_ready = 1'b0;
      hit_vld = 4'b0111;
      repeat (7) @(negedge clk);
      hit_vld = 4'h0;
      check("pre_clr_ovf", 64'(overflow), 64'd1);
      clr_pulse();
      check("clr_v", 64'(m_valid), 64'd0);
      check("clr_rdy", 64'(rdy), 64'd1);
      check("clr_ovf", 64'(ch_overflow), 64'd0);
      check("clr_cnt", drop_cnt, 64'd0);
      m_ready = 1'b1; hit_vld = 4'b0001; hit_fine[7:0] = 8'h99;
      @(negedge clk);
      hit_vld = 4'h0;
      @(negedge clk);
      check("clr_coarse0", m_data, 64'h0000_0000_0000_0099);

      // Asynchronous reset mid-stream.
      m_ready = 1'b0;
      hit_vld = 4'hF;
      repeat (7) @(negedge clk);
      hit_vld = 4'h0;
      check("pre_rst_ovf", 64'(overflow), 64'd1);
      #2 clr_n = 1'b0;
      #1;
      check("arst_v", 64'(m_valid), 64'd0);
      check("arst_rdy", 64'(rdy), 64'd1);
      check("arst_ovf", 64'(ch_overflow), 64'd0);
      check("arst_cnt", drop_cnt, 64'd0);
      @(negedge clk);
      clr_n = 1'b1; m_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
